// File: rtl/uart_time_frame_clock.sv
// uart_time_frame_clock: parses HEADER,H,M,S,TAIL set-time frames and keeps a free-running BCD 24-hour clock
module uart_time_frame_clock #(
  parameter int         CLK_FREQ    = 50_000_000,
  parameter logic [7:0] HEADER      = 8'h55,
  parameter logic [7:0] TAIL        = 8'hF0,
  parameter int         TIMEOUT_CYC = 500_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] Hour,
  output logic [7:0] Minute,
  output logic [7:0] Seconds,
  output logic       Set_Ok,
  output logic       Frame_Err
);
  localparam int TW = CLK_FREQ > 1 ? $clog2(CLK_FREQ) : 1;
  localparam int OW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_FREQ - 1);
  localparam logic [OW-1:0] TO_LAST = OW'(TIMEOUT_CYC - 1);
  typedef enum logic [2:0] {IDLE, GET_H, GET_M, GET_S, GET_TAIL} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick_cnt;
  logic [OW-1:0] to_cnt;
  logic [7:0] h_sh, m_sh, s_sh;
  logic tick, timeout, frame_ok, load, reject;
  function automatic logic bcd_ok(input logic [7:0] v);
    return v[7:4] <= 4'd9 && v[3:0] <= 4'd9;
  endfunction
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  assign tick = tick_cnt == TICK_LAST;
  assign timeout = state != IDLE && !rx_done && to_cnt == TO_LAST;
  assign frame_ok = rx_data == TAIL && bcd_ok(h_sh) && bcd_ok(m_sh) && bcd_ok(s_sh)
                    && h_sh <= 8'h23 && m_sh <= 8'h59 && s_sh <= 8'h59;
  // frame FSM state register
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else state <= state_n;
  // next state; a byte arriving on the timeout cycle takes priority over the timeout
  always_comb begin
    state_n = state;
    load = 1'b0;
    reject = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      reject = 1'b1;
    end else if (rx_done)
      case (state)
        IDLE:     state_n = rx_data == HEADER ? GET_H : IDLE;
        GET_H:    state_n = GET_M;
        GET_M:    state_n = GET_S;
        GET_S:    state_n = GET_TAIL;
        GET_TAIL: begin
          state_n = IDLE;
          load = frame_ok;
          reject = !frame_ok;
        end
        default:  state_n = IDLE;
      endcase
  end
  // inter-byte idle counter, only live while a frame is open
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) to_cnt <= '0;
    else to_cnt <= state_n == IDLE || rx_done ? '0 : to_cnt + OW'(1);
  // shadow capture of the H/M/S payload bytes
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      h_sh <= 8'h00;
      m_sh <= 8'h00;
      s_sh <= 8'h00;
    end else if (rx_done) begin
      if (state == GET_H) h_sh <= rx_data;
      if (state == GET_M) m_sh <= rx_data;
      if (state == GET_S) s_sh <= rx_data;
    end
  // 1 s prescaler; a load restarts the second so the new time lasts a full period
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) tick_cnt <= '0;
    else tick_cnt <= load || tick ? '0 : tick_cnt + TW'(1);
  // time registers: load beats a coincident tick, otherwise BCD carry chain on tick
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      Hour <= 8'h00;
      Minute <= 8'h00;
      Seconds <= 8'h00;
    end else if (load) begin
      Hour <= h_sh;
      Minute <= m_sh;
      Seconds <= s_sh;
    end else if (tick) begin
      Seconds <= Seconds == 8'h59 ? 8'h00 : bcd_inc(Seconds);
      if (Seconds == 8'h59) Minute <= Minute == 8'h59 ? 8'h00 : bcd_inc(Minute);
      if (Seconds == 8'h59 && Minute == 8'h59) Hour <= Hour == 8'h23 ? 8'h00 : bcd_inc(Hour);
    end
  // registered status pulses
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      Set_Ok <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      Set_Ok <= load;
      Frame_Err <= reject;
    end
endmodule

// File: tb/tb_uart_time_frame_clock.sv
// tb_uart_time_frame_clock: directed checks of frame parsing, BCD clock, timeout and reset
module tb_uart_time_frame_clock;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_done = 1'b0;
  logic [7:0] hour, minute, seconds;
  logic set_ok, frame_err;
  int tests = 0;
  int fails = 0;
  uart_time_frame_clock #(.CLK_FREQ(10), .HEADER(8'h55), .TAIL(8'hF0), .TIMEOUT_CYC(20)) dut (
    .Clk(clk), .Reset_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
    .Hour(hour), .Minute(minute), .Seconds(seconds), .Set_Ok(set_ok), .Frame_Err(frame_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_time(input string tag, input logic [23:0] exp);
    check(tag, {hour, minute, seconds} == exp ? 8'h01 : 8'h00, 8'h01);
    if ({hour, minute, seconds} !== exp)
      $display("  %s time %h:%h:%h expected %h", tag, hour, minute, seconds, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    cyc(1);
    rx_done = 1'b0;
  endtask
  task automatic frame(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic [7:0] t);
    send(8'h55);
    send(h);
    send(m);
    send(s);
    send(t);
  endtask
  initial begin
    cyc(2);
    check_time("reset_time", 24'h000000);
    check("reset_set_ok", {7'd0, set_ok}, 8'h00);
    check("reset_frame_err", {7'd0, frame_err}, 8'h00);
    rst_n = 1'b1;
    cyc(9);
    check("sec_before_tick", seconds, 8'h00);
    cyc(1);
    check("sec_01", seconds, 8'h01);
    cyc(10);
    check("sec_02", seconds, 8'h02);
    cyc(10);
    check_time("sec_03", 24'h000003);
    frame(8'h12, 8'h34, 8'h56, 8'hF0);
    check("load_set_ok", {7'd0, set_ok}, 8'h01);
    check("load_no_err", {7'd0, frame_err}, 8'h00);
    check_time("load_123456", 24'h123456);
    cyc(1);
    check("set_ok_one_cycle", {7'd0, set_ok}, 8'h00);
    cyc(8);
    check("hold_56", seconds, 8'h56);
    cyc(1);
    check("inc_57", seconds, 8'h57);
    frame(8'h23, 8'h59, 8'h58, 8'hF0);
    cyc(10);
    check_time("to_235959", 24'h235959);
    cyc(10);
    check_time("wrap_000000", 24'h000000);
    frame(8'h09, 8'h59, 8'h59, 8'hF0);
    cyc(10);
    check_time("to_100000", 24'h100000);
    frame(8'h19, 8'h59, 8'h59, 8'hF0);
    cyc(10);
    check_time("to_200000", 24'h200000);
    frame(8'h24, 8'h00, 8'h00, 8'hF0);
    check("err_hour24", {7'd0, frame_err}, 8'h01);
    check("no_ok_hour24", {7'd0, set_ok}, 8'h00);
    check_time("keep_hour24", 24'h200000);
    frame(8'h12, 8'h3A, 8'h00, 8'hF0);
    check("err_nibble", {7'd0, frame_err}, 8'h01);
    check_time("keep_nibble", 24'h200001);
    frame(8'h12, 8'h00, 8'h00, 8'hEE);
    check("err_tail", {7'd0, frame_err}, 8'h01);
    check("no_ok_tail", {7'd0, set_ok}, 8'h00);
    cyc(1);
    check("err_one_cycle", {7'd0, frame_err}, 8'h00);
    cyc(4);
    check_time("still_ticking", 24'h200002);
    send(8'h55);
    send(8'h12);
    cyc(19);
    check("timeout_not_yet", {7'd0, frame_err}, 8'h00);
    cyc(1);
    check("timeout_err", {7'd0, frame_err}, 8'h01);
    check_time("timeout_time", 24'h200004);
    frame(8'h01, 8'h02, 8'h03, 8'hF0);
    check("after_timeout_ok", {7'd0, set_ok}, 8'h01);
    check_time("load_010203", 24'h010203);
    send(8'h00);
    send(8'hFF);
    frame(8'h07, 8'h08, 8'h09, 8'hF0);
    check("noise_ok", {7'd0, set_ok}, 8'h01);
    check("noise_no_err", {7'd0, frame_err}, 8'h00);
    check_time("load_070809", 24'h070809);
    cyc(5);
    frame(8'h11, 8'h22, 8'h33, 8'hF0);
    check_time("load_on_tick", 24'h112233);
    cyc(9);
    check("tick_restarted", seconds, 8'h33);
    cyc(1);
    check("tick_after_load", seconds, 8'h34);
    send(8'h55);
    send(8'h12);
    rst_n = 1'b0;
    #2;
    check_time("async_reset", 24'h000000);
    #4;
    rst_n = 1'b1;
    cyc(1);
    send(8'h13);
    send(8'h14);
    send(8'hF0);
    check("partial_discarded", {7'd0, set_ok}, 8'h00);
    check_time("after_reset", 24'h000000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
